// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store engine for a byte-addressed memory with
// asynchronous 4-byte reads and 4-byte falling-edge writes.
//   req_*       : request from MEM stage (valid/ready handshake)
//   mem_*       : memory port (address, write enable, write data, read data)
//   wb_*        : registered load writeback (1-cycle valid pulse)
//   misalign    : registered 1-cycle fault pulse
//   stall       : ~req_ready
// Word stores and all loads complete in the accept cycle. Byte and half stores
// read-modify-write the 4-byte window at the address over two extra cycles.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_address,
  output logic        mem_writeEnable,
  output logic [31:0] mem_writeData,
  input  logic [31:0] mem_readData,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;

  logic        accept, is_ld, is_st, mis;
  logic [31:0] ld_ext, merged;

  assign req_ready = (state_q == IDLE) && !reset;
  assign stall     = ~req_ready;
  assign accept    = req_valid && req_ready;
  // Exactly one of load/store qualifies; both or neither is a no-op.
  assign is_ld     = req_is_load  & ~req_is_store;
  assign is_st     = req_is_store & ~req_is_load;
  assign mis       = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    ld_ext = mem_readData;
    unique case (req_size)
      2'b00:   ld_ext = {{24{~req_unsigned & mem_readData[7]}},  mem_readData[7:0]};
      2'b01:   ld_ext = {{16{~req_unsigned & mem_readData[15]}}, mem_readData[15:0]};
      default: ld_ext = mem_readData;
    endcase
  end

  assign merged = (size_q == 2'b00) ? {merge_q[31:8],  wdata_q[7:0]}
                                    : {merge_q[31:16], wdata_q};

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    size_d          = size_q;
    wdata_d         = wdata_q;
    merge_d         = merge_q;
    wb_valid_d      = 1'b0;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    misalign_d      = 1'b0;
    mem_address     = req_addr;
    mem_writeEnable = 1'b0;
    mem_writeData   = req_wdata;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if ((is_ld || is_st) && mis) begin
            misalign_d = 1'b1;
          end else if (is_ld) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = req_rd;
            wb_data_d  = ld_ext;
          end else if (is_st && req_size == 2'b10) begin
            mem_writeEnable = 1'b1;
          end else if (is_st) begin
            addr_d  = req_addr;
            size_d  = req_size;
            wdata_d = req_wdata[15:0];
            state_d = RMW_RD;
          end
        end
      end
      RMW_RD: begin
        mem_address = addr_q;
        merge_d     = mem_readData;
        state_d     = RMW_WR;
      end
      RMW_WR: begin
        mem_address     = addr_q;
        mem_writeData   = merged;
        // Reset landing here must abort the write, not just the next state.
        mem_writeEnable = !reset;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_load, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_writeEnable;
  logic        wb_valid, misalign, stall;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .mem_address(mem_address), .mem_writeEnable(mem_writeEnable),
    .mem_writeData(mem_writeData), .mem_readData(mem_readData), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign), .stall(stall)
  );

  always #5 clk = ~clk;

  // 4 KiB byte memory; addresses wrap modulo 4096.
  logic [7:0]  mem [0:4095];
  logic [11:0] ma;
  assign ma = mem_address[11:0];
  assign mem_readData = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

  int we_seen = 0;
  logic mon = 1'b0;
  always @(negedge clk) begin
    if (mem_writeEnable) begin
      mem[ma]         = mem_writeData[7:0];
      mem[ma + 12'd1] = mem_writeData[15:8];
      mem[ma + 12'd2] = mem_writeData[23:16];
      mem[ma + 12'd3] = mem_writeData[31:24];
      if (mon) we_seen++;
    end
  end

  function automatic logic [31:0] rdw(input logic [11:0] a);
    return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
  endfunction

  task automatic wrw(input logic [11:0] a, input logic [31:0] d);
    mem[a] = d[7:0]; mem[a + 12'd1] = d[15:8];
    mem[a + 12'd2] = d[23:16]; mem[a + 12'd3] = d[31:24];
  endtask

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        ld, st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        exp_we, exp_wbv;
    logic [31:0] exp_wbd;
    logic        exp_mis;
  } vec_t;

  vec_t vt [16];

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    req_valid = 0; req_is_load = 0; req_is_store = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
  endtask

  // Entered at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic apply_vec(input string nm, input vec_t v);
    req_valid = 1; req_is_load = v.ld; req_is_store = v.st; req_size = v.sz;
    req_unsigned = v.uns; req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    #2;
    chk({nm, ".ready"}, {31'b0, req_ready}, 32'd1);
    chk({nm, ".we"}, {31'b0, mem_writeEnable}, {31'b0, v.exp_we});
    chk({nm, ".addr"}, mem_address, v.addr);
    if (v.exp_we) chk({nm, ".wdata"}, mem_writeData, v.wdata);
    cyc();
    idle_in();
    chk({nm, ".wbv"}, {31'b0, wb_valid}, {31'b0, v.exp_wbv});
    chk({nm, ".mis"}, {31'b0, misalign}, {31'b0, v.exp_mis});
    if (v.exp_wbv) begin
      chk({nm, ".wbd"}, wb_data, v.exp_wbd);
      chk({nm, ".wbrd"}, {27'b0, wb_rd}, {27'b0, v.rd});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //         ld st  sz     uns addr          wdata         rd  we wbv exp_wbd        mis
    vt[0]  = '{0, 1, 2'b10, 0, 32'h100,      32'hDEADBEEF, 0,  1, 0, 32'h0,         0};
    vt[1]  = '{1, 0, 2'b10, 0, 32'h100,      32'h0,        5,  0, 1, 32'hDEADBEEF,  0};
    vt[2]  = '{1, 0, 2'b00, 0, 32'h100,      32'h0,        6,  0, 1, 32'hFFFFFFEF,  0};
    vt[3]  = '{1, 0, 2'b00, 1, 32'h100,      32'h0,        7,  0, 1, 32'h000000EF,  0};
    vt[4]  = '{1, 0, 2'b01, 0, 32'h102,      32'h0,        8,  0, 1, 32'hFFFFDEAD,  0};
    vt[5]  = '{1, 0, 2'b01, 1, 32'h102,      32'h0,        9,  0, 1, 32'h0000DEAD,  0};
    vt[6]  = '{1, 0, 2'b00, 0, 32'h101,      32'h0,        10, 0, 1, 32'hFFFFFFBE,  0};
    vt[7]  = '{1, 0, 2'b10, 0, 32'h101,      32'h0,        11, 0, 0, 32'h0,         1};
    vt[8]  = '{0, 1, 2'b01, 0, 32'h203,      32'h00007777, 0,  0, 0, 32'h0,         1};
    vt[9]  = '{1, 0, 2'b11, 0, 32'h100,      32'h0,        12, 0, 0, 32'h0,         1};
    vt[10] = '{1, 1, 2'b10, 0, 32'h100,      32'h55555555, 13, 0, 0, 32'h0,         0};
    vt[11] = '{0, 0, 2'b10, 0, 32'h100,      32'h66666666, 14, 0, 0, 32'h0,         0};
    vt[12] = '{0, 1, 2'b10, 0, 32'hFFFFFFFC, 32'h01020304, 0,  1, 0, 32'h0,         0};
    vt[13] = '{1, 0, 2'b10, 0, 32'hFFFFFFFC, 32'h0,        15, 0, 1, 32'h01020304,  0};
    vt[14] = '{1, 0, 2'b01, 0, 32'hFFFFFFFC, 32'h0,        16, 0, 1, 32'h00000304,  0};
    vt[15] = '{0, 1, 2'b10, 0, 32'h102,      32'h77777777, 0,  0, 0, 32'h0,         1};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    wrw(12'h200, 32'h11223344);

    // Reset: a valid word store is presented and must not write.
    reset = 1; idle_in();
    req_valid = 1; req_is_store = 1; req_size = 2'b10; req_addr = 32'h400; req_wdata = 32'hFFFFFFFF;
    cyc(); cyc(); #2;
    chk("rst.ready", {31'b0, req_ready}, 32'd0);
    chk("rst.we", {31'b0, mem_writeEnable}, 32'd0);
    chk("rst.stall", {31'b0, stall}, 32'd1);
    cyc(); reset = 0; idle_in(); #2;
    chk("rst.ready_after", {31'b0, req_ready}, 32'd1);
    chk("rst.wbv", {31'b0, wb_valid}, 32'd0);
    chk("rst.wbd", wb_data, 32'd0);
    chk("rst.wbrd", {27'b0, wb_rd}, 32'd0);
    chk("rst.mis", {31'b0, misalign}, 32'd0);
    chk("rst.mem400", rdw(12'h400), 32'h0);
    cyc();

    for (int i = 0; i < 16; i++) apply_vec($sformatf("vec%0d", i), vt[i]);
    chk("mem100_unchanged", rdw(12'h100), 32'hDEADBEEF);
    chk("mem200_unchanged", rdw(12'h200), 32'h11223344);
    chk("memFFC", rdw(12'hFFC), 32'h01020304);

    // Byte store RMW at 0x200 then load it back immediately.
    req_valid = 1; req_is_store = 1; req_size = 2'b00; req_addr = 32'h200; req_wdata = 32'hFFFFFFAB;
    #2;
    chk("sb.t0.we", {31'b0, mem_writeEnable}, 32'd0);
    cyc(); idle_in(); #2;
    chk("sb.t1.ready", {31'b0, req_ready}, 32'd0);
    chk("sb.t1.stall", {31'b0, stall}, 32'd1);
    chk("sb.t1.we", {31'b0, mem_writeEnable}, 32'd0);
    chk("sb.t1.addr", mem_address, 32'h200);
    cyc(); #2;
    chk("sb.t2.ready", {31'b0, req_ready}, 32'd0);
    chk("sb.t2.we", {31'b0, mem_writeEnable}, 32'd1);
    chk("sb.t2.addr", mem_address, 32'h200);
    chk("sb.t2.wdata", mem_writeData, 32'h112233AB);
    cyc();
    chk("sb.mem", rdw(12'h200), 32'h112233AB);
    chk("sb.wbv", {31'b0, wb_valid}, 32'd0);
    v = '{1, 0, 2'b00, 0, 32'h200, 32'h0, 3, 0, 1, 32'hFFFFFFAB, 0};
    apply_vec("sb.lbs", v);
    v = '{1, 0, 2'b00, 1, 32'h200, 32'h0, 4, 0, 1, 32'h000000AB, 0};
    apply_vec("sb.lbu", v);

    // Half store over 0xCAFEBABE at 0x202.
    wrw(12'h202, 32'hCAFEBABE);
    req_valid = 1; req_is_store = 1; req_size = 2'b01; req_addr = 32'h202; req_wdata = 32'h12348001;
    cyc(); idle_in(); #2;
    chk("sh.t1.ready", {31'b0, req_ready}, 32'd0);
    cyc(); #2;
    chk("sh.t2.we", {31'b0, mem_writeEnable}, 32'd1);
    chk("sh.t2.wdata", mem_writeData, 32'hCAFE8001);
    cyc();
    chk("sh.mem", rdw(12'h202), 32'hCAFE8001);
    v = '{1, 0, 2'b01, 0, 32'h202, 32'h0, 17, 0, 1, 32'hFFFF8001, 0};
    apply_vec("sh.lhs", v);

    // Reset during RMW_RD aborts the byte store at 0x300.
    wrw(12'h300, 32'h99999999);
    mon = 1; we_seen = 0;
    req_valid = 1; req_is_store = 1; req_size = 2'b00; req_addr = 32'h300; req_wdata = 32'h5A;
    cyc(); idle_in(); reset = 1; #2;
    chk("ra.rd.we", {31'b0, mem_writeEnable}, 32'd0);
    chk("ra.rd.ready", {31'b0, req_ready}, 32'd0);
    cyc(); reset = 0; #2;
    chk("ra.ready", {31'b0, req_ready}, 32'd1);
    chk("ra.we", {31'b0, mem_writeEnable}, 32'd0);
    chk("ra.wbv", {31'b0, wb_valid}, 32'd0);
    chk("ra.wbd", wb_data, 32'd0);
    chk("ra.wbrd", {27'b0, wb_rd}, 32'd0);
    chk("ra.mis", {31'b0, misalign}, 32'd0);
    cyc(); cyc(); cyc();
    chk("ra.mem", rdw(12'h300), 32'h99999999);

    // Reset during RMW_WR must suppress the write in that very cycle.
    wrw(12'h304, 32'h88888888);
    req_valid = 1; req_is_store = 1; req_size = 2'b00; req_addr = 32'h304; req_wdata = 32'h5A;
    cyc(); idle_in();
    cyc(); reset = 1; #2;
    chk("rw.we", {31'b0, mem_writeEnable}, 32'd0);
    cyc(); reset = 0; #2;
    chk("rw.ready", {31'b0, req_ready}, 32'd1);
    cyc(); cyc();
    chk("rw.mem", rdw(12'h304), 32'h88888888);
    chk("ra.we_seen", we_seen, 32'd0);
    mon = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  MEM-stage request present.
REQ-004 req_ready  output  1  unit can accept; transfer occurs when req_valid && req_ready.
REQ-005 req_is_load  input  1  request is a load.
REQ-006 req_is_store  input  1  request is a store.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 req_rd  input  5  load destination register.
REQ-012 mem_address  output  32  to memory address port.
REQ-013 mem_writeEnable  output  1  to memory write enable; memory writes 4 bytes addr..addr+3 on falling clk edge.
REQ-014 mem_writeData  output  32  to memory write data, little-endian.
REQ-015 mem_readData  input  32  from memory, asynchronous read of bytes addr..addr+3.
REQ-016 wb_valid  output  1  registered load result valid, one-cycle pulse.
REQ-017 wb_rd  output  5  registered destination of load result.
REQ-018 wb_data  output  32  registered extended load result.
REQ-019 misalign  output  1  registered one-cycle fault pulse.
REQ-020 stall  output  1  equals ~req_ready; holds upstream pipeline.

Function
REQ-021 States SHALL be IDLE, RMW_RD, RMW_WR; req_ready SHALL be 1 only in IDLE and not in reset.
REQ-022 Misaligned SHALL mean half with addr[0]=1, word with addr[1:0]!=0, or size 11; accepted misaligned load/store SHALL cause no memory write, misalign=1 next cycle, wb_valid=0.
REQ-023 Accepted request with both or neither of req_is_load/req_is_store SHALL be a no-op: no write, no wb_valid, no misalign.
REQ-024 In IDLE mem_address SHALL equal req_addr combinationally; mem_writeEnable SHALL be 0 except per REQ-026.
REQ-025 Aligned load accepted in cycle T: wb_data SHALL capture mem_readData bits [7:0]/[15:0]/[31:0] per size, sign- or zero-extended per req_unsigned, with wb_valid=1 and wb_rd=req_rd in T+1; latency 1; state stays IDLE.
REQ-026 Aligned word store accepted in T: mem_writeEnable=1, mem_writeData=req_wdata in T; state stays IDLE; no wb_valid.
REQ-027 Aligned byte/half store accepted in T: latch addr, size, wdata; go RMW_RD.
REQ-028 RMW_RD: mem_address=latched addr, mem_writeEnable=0; on the edge capture mem_readData into merge register; go RMW_WR.
REQ-029 RMW_WR: mem_address=latched addr, mem_writeEnable=1, mem_writeData = merge register with bits [7:0] (byte) or [15:0] (half) replaced by latched wdata; go IDLE.
REQ-030 Sub-word store SHALL occupy 3 cycles (req_ready low in T+1, T+2; high again T+3).
REQ-031 wb_valid and misalign SHALL be 0 in any cycle not following an accepted qualifying request.
REQ-032 Address arithmetic SHALL be 32-bit unsigned; no wrap check, addr 0xFFFFFFFC word access passes through unchanged.
REQ-033 Load accepted in cycle after RMW_WR SHALL observe the written data (write completes at RMW_WR falling edge).

Reset
REQ-034 reset SHALL force state IDLE, wb_valid=0, wb_rd=0, wb_data=0, misalign=0, merge register=0 at the next edge.
REQ-035 While reset is high, mem_writeEnable=0 and req_ready=0.
REQ-036 Reset asserted in RMW_RD or RMW_WR SHALL abort the store with no memory write in the reset cycle or after.

Verification
REQ-037 Word store 0xDEADBEEF @0x100, then load word signed @0x100 -> writeEnable one cycle, wb_valid next cycle, wb_data=0xDEADBEEF.
REQ-038 Memory @0x200=0x11223344; store byte 0xAB @0x200 -> stall 2 cycles, written word 0x112233AB; load byte signed -> 0xFFFFFFAB, unsigned -> 0x000000AB.
REQ-039 Store half 0x8001 @0x202 over 0xCAFEBABE -> written 0xCAFE8001 at 0x202..0x205 base; load half signed @0x202 -> 0xFFFF8001.
REQ-040 Load word @0x101 and store half @0x203 -> misalign=1 next cycle, no writeEnable, wb_valid=0, memory unchanged.
REQ-041 Reset in RMW_RD of byte store @0x300 -> no writeEnable ever asserted, outputs zero, req_ready=1 first cycle after reset deasserts.
REQ-042 Both req_is_load and req_is_store high @0x100 -> accepted, no write, wb_valid=0, misalign=0.
